// File: rtl/usb_fe_link_ctrl.sv
// Link-level controller between usb_sie and the full-speed frontend: pull-up connect,
// bus-reset, suspend/resume detection and remote-wakeup K signalling with TX arbitration.
module usb_fe_link_ctrl #(
    parameter int unsigned CONNECT_DLY_CYC = 4800,
    parameter int unsigned RESET_DET_CYC   = 120,
    parameter int unsigned SUSP_DET_CYC    = 144000,
    parameter int unsigned WAKE_IDLE_CYC   = 96000,
    parameter int unsigned WAKE_DRV_CYC    = 96000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic connect_en,
    input  logic wakeup_req,
    input  logic sie_dp_tx,
    input  logic sie_dn_tx,
    input  logic sie_tx_oen,
    input  logic line_dp,
    input  logic line_dn,
    output logic fe_dp_tx,
    output logic fe_dn_tx,
    output logic fe_tx_oen,
    output logic fe_pu,
    output logic phy_suspend,
    output logic bus_reset,
    output logic reset_active,
    output logic suspended,
    output logic resume_det,
    output logic wakeup_busy
);

    localparam int unsigned MAX_AB  = (CONNECT_DLY_CYC > RESET_DET_CYC) ?
                                      CONNECT_DLY_CYC : RESET_DET_CYC;
    localparam int unsigned MAX_CD  = (SUSP_DET_CYC > WAKE_DRV_CYC) ? SUSP_DET_CYC : WAKE_DRV_CYC;
    localparam int unsigned MAX_ABD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_MAX = (MAX_ABD > WAKE_IDLE_CYC) ? MAX_ABD : WAKE_IDLE_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned DWELL_W = $clog2(WAKE_IDLE_CYC + 1);

    localparam logic [CNT_W-1:0]   CONNECT_LAST = CNT_W'(CONNECT_DLY_CYC - 1);
    localparam logic [CNT_W-1:0]   RESET_LAST   = CNT_W'(RESET_DET_CYC - 1);
    localparam logic [CNT_W-1:0]   SUSP_LAST    = CNT_W'(SUSP_DET_CYC - 1);
    localparam logic [CNT_W-1:0]   WAKE_LAST    = CNT_W'(WAKE_DRV_CYC - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
    localparam logic [DWELL_W-1:0] WAKE_IDLE    = DWELL_W'(WAKE_IDLE_CYC);

    typedef enum logic [2:0] {
        StDisconnected,
        StAttach,
        StActive,
        StBusReset,
        StSuspended,
        StWakeDrive,
        StResumeWait
    } state_e;

    // Qualifying line condition that the shared run counter is currently tracking.
    typedef enum logic [1:0] {
        ClsOther,
        ClsSe0,
        ClsIdle,
        ClsK
    } line_cls_e;

    state_e              state_q, state_d;
    line_cls_e           cls, cls_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d, run;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic                bus_reset_d, resume_d;
    logic                sie_owns_q;
    logic                dp_meta_q, dp_sync_q, dn_meta_q, dn_sync_q;
    logic                line_j, line_k, line_se0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_meta_q <= 1'b0;
            dp_sync_q <= 1'b0;
            dn_meta_q <= 1'b0;
            dn_sync_q <= 1'b0;
        end else begin
            dp_meta_q <= line_dp;
            dp_sync_q <= dp_meta_q;
            dn_meta_q <= line_dn;
            dn_sync_q <= dn_meta_q;
        end
    end

    // 11 is not a legal full-speed state and is folded into SE0.
    assign line_j   = dp_sync_q & ~dn_sync_q;
    assign line_k   = ~dp_sync_q & dn_sync_q;
    assign line_se0 = ~(line_j | line_k);

    always_comb begin
        cls = ClsOther;
        if (line_se0) begin
            cls = ClsSe0;
        end else if (line_k) begin
            cls = ClsK;
        end else if (!sie_tx_oen) begin
            cls = ClsIdle;
        end
    end

    // A change of condition class restarts the run even if the counter is mid-count.
    assign run = (cls == cls_q) ? cnt_q : '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        bus_reset_d = 1'b0;
        resume_d    = 1'b0;
        case (state_q)
            StDisconnected: state_d = StAttach;
            StAttach: begin
                if (cnt_q == CONNECT_LAST) begin
                    state_d = StActive;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StActive: begin
                if (cls == ClsSe0) begin
                    if (run == RESET_LAST) begin
                        state_d     = StBusReset;
                        bus_reset_d = 1'b1;
                    end else begin
                        cnt_d = run + 1'b1;
                    end
                end else if (cls == ClsIdle) begin
                    if (run == SUSP_LAST) begin
                        state_d = StSuspended;
                    end else begin
                        cnt_d = run + 1'b1;
                    end
                end
            end
            StBusReset: begin
                if (line_j) begin
                    state_d = StActive;
                end
            end
            StSuspended: begin
                if (cls == ClsSe0) begin
                    if (run == RESET_LAST) begin
                        state_d     = StBusReset;
                        bus_reset_d = 1'b1;
                    end else begin
                        cnt_d = run + 1'b1;
                    end
                end else if (cls == ClsK) begin
                    if (run == CNT_ONE) begin
                        state_d  = StResumeWait;
                        resume_d = 1'b1;
                    end else begin
                        cnt_d = run + 1'b1;
                    end
                end
                // Host resume and bus reset take precedence over remote wakeup.
                if (state_d == StSuspended && wakeup_req && dwell_q >= WAKE_IDLE) begin
                    state_d = StWakeDrive;
                end
            end
            StWakeDrive: begin
                if (cnt_q == WAKE_LAST) begin
                    state_d = StResumeWait;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResumeWait: begin
                if (cls == ClsSe0) begin
                    if (run == RESET_LAST) begin
                        state_d     = StBusReset;
                        bus_reset_d = 1'b1;
                    end else begin
                        cnt_d = run + 1'b1;
                    end
                end else if (line_j && cnt_q != '0) begin
                    // cnt_q is non-zero only if the previous cycle was SE0: this J ends the EOP.
                    state_d = StActive;
                end
            end
            default: state_d = StDisconnected;
        endcase

        if (!connect_en) begin
            state_d     = StDisconnected;
            bus_reset_d = 1'b0;
            resume_d    = 1'b0;
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        dwell_d = '0;
        if (state_q == StSuspended && state_d == StSuspended) begin
            dwell_d = (dwell_q == WAKE_IDLE) ? dwell_q : dwell_q + 1'b1;
        end
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StDisconnected;
            cnt_q        <= '0;
            dwell_q      <= '0;
            cls_q        <= ClsOther;
            sie_owns_q   <= 1'b0;
            fe_pu        <= 1'b0;
            phy_suspend  <= 1'b0;
            bus_reset    <= 1'b0;
            reset_active <= 1'b0;
            suspended    <= 1'b0;
            resume_det   <= 1'b0;
            wakeup_busy  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dwell_q      <= dwell_d;
            cls_q        <= cls;
            sie_owns_q   <= (state_d == StActive) || (state_d == StBusReset) ||
                            (state_d == StResumeWait);
            fe_pu        <= (state_d != StDisconnected) && (state_d != StAttach);
            phy_suspend  <= (state_d == StSuspended);
            bus_reset    <= bus_reset_d;
            reset_active <= (state_d == StBusReset);
            suspended    <= (state_d == StSuspended);
            resume_det   <= resume_d;
            wakeup_busy  <= (state_d == StWakeDrive);
        end
    end

    // Zero-latency path for the SIE; the wakeup driver forces K while it owns the bus.
    always_comb begin
        fe_tx_oen = 1'b0;
        fe_dp_tx  = 1'b0;
        fe_dn_tx  = 1'b0;
        if (wakeup_busy) begin
            fe_tx_oen = 1'b1;
            fe_dn_tx  = 1'b1;
        end else if (sie_owns_q && sie_tx_oen) begin
            fe_tx_oen = 1'b1;
            fe_dp_tx  = sie_dp_tx;
            fe_dn_tx  = sie_dn_tx;
        end
    end

endmodule

// File: tb/tb_usb_fe_link_ctrl.sv
// Self-checking bench for usb_fe_link_ctrl: directed scenarios plus randomized line/SIE
// traffic, all compared every cycle against a run-length behavioural model.
module tb_usb_fe_link_ctrl;

    localparam int unsigned CONN  = 20;
    localparam int unsigned RSTC  = 6;
    localparam int unsigned SUSP  = 40;
    localparam int unsigned WIDLE = 30;
    localparam int unsigned WDRV  = 25;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic connect_en = 1'b0, wakeup_req = 1'b0;
    logic sie_dp_tx = 1'b0, sie_dn_tx = 1'b0, sie_tx_oen = 1'b0;
    logic line_dp = 1'b1, line_dn = 1'b0;
    logic fe_dp_tx, fe_dn_tx, fe_tx_oen, fe_pu, phy_suspend, bus_reset;
    logic reset_active, suspended, resume_det, wakeup_busy;

    always #5 clk = ~clk;

    usb_fe_link_ctrl #(
        .CONNECT_DLY_CYC(CONN),
        .RESET_DET_CYC  (RSTC),
        .SUSP_DET_CYC   (SUSP),
        .WAKE_IDLE_CYC  (WIDLE),
        .WAKE_DRV_CYC   (WDRV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .connect_en  (connect_en),
        .wakeup_req  (wakeup_req),
        .sie_dp_tx   (sie_dp_tx),
        .sie_dn_tx   (sie_dn_tx),
        .sie_tx_oen  (sie_tx_oen),
        .line_dp     (line_dp),
        .line_dn     (line_dn),
        .fe_dp_tx    (fe_dp_tx),
        .fe_dn_tx    (fe_dn_tx),
        .fe_tx_oen   (fe_tx_oen),
        .fe_pu       (fe_pu),
        .phy_suspend (phy_suspend),
        .bus_reset   (bus_reset),
        .reset_active(reset_active),
        .suspended   (suspended),
        .resume_det  (resume_det),
        .wakeup_busy (wakeup_busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_bus_reset = 0;
    int n_resume = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: link mode plus run lengths of each line condition within the mode.
    typedef enum int {MDisc, MAttach, MActive, MBusRst, MSusp, MWake, MResWait} mode_t;
    mode_t m_mode;
    int m_age, m_se0_run, m_idle_run, m_k_run;
    bit m_bus_reset, m_resume;
    logic [1:0] m_s1, m_s2;

    task automatic model_reset();
        m_mode = MDisc;
        m_age = 0;
        m_se0_run = 0;
        m_idle_run = 0;
        m_k_run = 0;
        m_bus_reset = 1'b0;
        m_resume = 1'b0;
        m_s1 = 2'b00;
        m_s2 = 2'b00;
    endtask

    task automatic model_step();
        bit j, k, se0;
        int prev_se0;
        mode_t nxt;
        j = (m_s2 == 2'b10);
        k = (m_s2 == 2'b01);
        se0 = !j && !k;
        prev_se0 = m_se0_run;
        m_se0_run = se0 ? m_se0_run + 1 : 0;
        m_idle_run = (j && !sie_tx_oen) ? m_idle_run + 1 : 0;
        m_k_run = k ? m_k_run + 1 : 0;
        nxt = m_mode;
        m_bus_reset = 1'b0;
        m_resume = 1'b0;
        if (!connect_en) begin
            nxt = MDisc;
        end else begin
            case (m_mode)
                MDisc:   nxt = MAttach;
                MAttach: if (m_age == CONN - 1) nxt = MActive;
                MActive: begin
                    if (m_se0_run == RSTC) begin
                        nxt = MBusRst;
                        m_bus_reset = 1'b1;
                    end else if (m_idle_run == SUSP) begin
                        nxt = MSusp;
                    end
                end
                MBusRst: if (j) nxt = MActive;
                MSusp: begin
                    if (m_se0_run == RSTC) begin
                        nxt = MBusRst;
                        m_bus_reset = 1'b1;
                    end else if (m_k_run == 2) begin
                        nxt = MResWait;
                        m_resume = 1'b1;
                    end else if (wakeup_req && m_age >= WIDLE) begin
                        nxt = MWake;
                    end
                end
                MWake: if (m_age == WDRV - 1) nxt = MResWait;
                MResWait: begin
                    if (m_se0_run == RSTC) begin
                        nxt = MBusRst;
                        m_bus_reset = 1'b1;
                    end else if (j && prev_se0 > 0) begin
                        nxt = MActive;
                    end
                end
                default: nxt = MDisc;
            endcase
        end
        m_s2 = m_s1;
        m_s1 = {line_dp, line_dn};
        if (nxt != m_mode) begin
            m_mode = nxt;
            m_age = 0;
            m_se0_run = 0;
            m_idle_run = 0;
            m_k_run = 0;
        end else begin
            m_age++;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (bus_reset === 1'b1) n_bus_reset++;
        if (resume_det === 1'b1) n_resume++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit pass, wake;
            pass = (m_mode == MActive) || (m_mode == MBusRst) || (m_mode == MResWait);
            wake = (m_mode == MWake);
            check("fe_pu", fe_pu, m_mode != MDisc && m_mode != MAttach);
            check("phy_suspend", phy_suspend, m_mode == MSusp);
            check("suspended", suspended, m_mode == MSusp);
            check("reset_active", reset_active, m_mode == MBusRst);
            check("wakeup_busy", wakeup_busy, wake);
            check("bus_reset", bus_reset, m_bus_reset);
            check("resume_det", resume_det, m_resume);
            check("fe_tx_oen", fe_tx_oen, wake || (pass && sie_tx_oen));
            check("fe_dp_tx", fe_dp_tx, !wake && pass && sie_tx_oen && sie_dp_tx);
            check("fe_dn_tx", fe_dn_tx, wake || (pass && sie_tx_oen && sie_dn_tx));
        end
    end

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_line(input logic [1:0] v);
        {line_dp, line_dn} = v;
    endtask

    task automatic wait_suspended(output int c);
        c = 0;
        while (suspended !== 1'b1 && c < 300) begin
            hold(1);
            c++;
        end
    endtask

    localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00;

    initial begin
        int c;
        int len;
        int kind;
        model_reset();
        hold(3);
        check("rst_fe_pu", fe_pu, 1'b0);
        check("rst_fe_tx_oen", fe_tx_oen, 1'b0);
        check("rst_suspended", suspended, 1'b0);
        check("rst_phy_suspend", phy_suspend, 1'b0);
        check("rst_wakeup_busy", wakeup_busy, 1'b0);
        check("rst_reset_active", reset_active, 1'b0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        hold(2);

        // Aborted attach, then a full connect delay.
        connect_en = 1'b1;
        hold(8);
        connect_en = 1'b0;
        hold(3);
        check("attach_abort_pu", fe_pu, 1'b0);
        connect_en = 1'b1;
        hold(CONN);
        check("connect_early_pu", fe_pu, 1'b0);
        hold(1);
        check("connect_pu", fe_pu, 1'b1);

        // SE0 one cycle short of a reset, then a real reset held past detection.
        set_line(LSE0);
        hold(RSTC - 1);
        set_line(LJ);
        hold(10);
        check_int("short_se0_resets", n_bus_reset, 0);
        set_line(LSE0);
        hold(2 * RSTC);
        check("reset_active_held", reset_active, 1'b1);
        check_int("bus_reset_pulses", n_bus_reset, 1);
        set_line(LJ);
        hold(5);
        check("reset_active_clear", reset_active, 1'b0);
        check_int("bus_reset_pulses_end", n_bus_reset, 1);

        // K glitch restarts idle count; suspend follows SUSP synchronised J cycles later.
        hold(30);
        set_line(LK);
        hold(1);
        set_line(LJ);
        wait_suspended(c);
        check_int("suspend_latency", c, SUSP + 2);
        check("phy_suspend_on", phy_suspend, 1'b1);

        // Remote wakeup: request from dwell 0 waits for WIDLE, drives K for WDRV cycles.
        wakeup_req = 1'b1;
        sie_tx_oen = 1'b1;
        sie_dp_tx = 1'b1;
        sie_dn_tx = 1'b0;
        c = 0;
        while (wakeup_busy !== 1'b1 && c < 300) begin
            hold(1);
            c++;
        end
        check_int("wake_start", c, WIDLE + 1);
        check("wake_oen", fe_tx_oen, 1'b1);
        check("wake_dp", fe_dp_tx, 1'b0);
        check("wake_dn", fe_dn_tx, 1'b1);
        c = 0;
        while (wakeup_busy === 1'b1 && c < 300) begin
            hold(1);
            c++;
        end
        check_int("wake_len", c, WDRV);
        wakeup_req = 1'b0;
        sie_tx_oen = 1'b0;
        check("rw_phy_suspend", phy_suspend, 1'b0);

        // EOP back to ACTIVE; SIE path must be transparent there.
        set_line(LSE0);
        hold(2);
        set_line(LJ);
        hold(5);
        sie_tx_oen = 1'b1;
        sie_dp_tx = 1'b1;
        sie_dn_tx = 1'b0;
        #1;
        check("active_pass_oen", fe_tx_oen, 1'b1);
        check("active_pass_dp", fe_dp_tx, 1'b1);
        hold(1);
        sie_tx_oen = 1'b0;

        // Host resume from suspend.
        wait_suspended(c);
        check("resuspend", suspended, 1'b1);
        set_line(LK);
        c = 0;
        while (resume_det !== 1'b1 && c < 50) begin
            hold(1);
            c++;
        end
        check_int("resume_latency", c, 4);
        check("resume_phy", phy_suspend, 1'b0);
        hold(26);
        set_line(LSE0);
        hold(2);
        set_line(LJ);
        hold(3);
        check_int("resume_pulses", n_resume, 1);

        // Asynchronous reset in the middle of wakeup drive.
        wait_suspended(c);
        wakeup_req = 1'b1;
        c = 0;
        while (wakeup_busy !== 1'b1 && c < 300) begin
            hold(1);
            c++;
        end
        hold(5);
        check("pre_rst_oen", fe_tx_oen, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_oen", fe_tx_oen, 1'b0);
        check("async_rst_dn", fe_dn_tx, 1'b0);
        check("async_rst_busy", wakeup_busy, 1'b0);
        check("async_rst_pu", fe_pu, 1'b0);
        hold(2);
        rst_n = 1'b1;
        wakeup_req = 1'b0;
        hold(1);
        check("post_rst_pu", fe_pu, 1'b0);

        // Randomized segments of line states, SIE traffic, wakeup and disconnects.
        for (int s = 0; s < 80; s++) begin
            kind = $urandom_range(0, 9);
            wakeup_req = ($urandom_range(0, 3) == 0);
            sie_tx_oen = 1'b0;
            connect_en = 1'b1;
            set_line(LJ);
            len = $urandom_range(1, 60);
            case (kind)
                3: begin set_line(LSE0); len = $urandom_range(1, RSTC + 3); end
                4: begin set_line(LK); len = $urandom_range(1, 4); end
                5: begin set_line(LK); len = $urandom_range(5, 40); end
                8: begin wakeup_req = 1'b1; len = $urandom_range(40, 120); end
                9: begin connect_en = ($urandom_range(0, 2) != 0); len = $urandom_range(1, 4); end
                default: ;
            endcase
            for (int i = 0; i < len; i++) begin
                if (kind == 6) begin
                    sie_tx_oen = 1'b1;
                    sie_dp_tx = 1'($urandom_range(0, 1));
                    sie_dn_tx = 1'($urandom_range(0, 1));
                    set_line(2'($urandom_range(0, 3)));
                end else if (kind == 7) begin
                    sie_tx_oen = 1'($urandom_range(0, 1));
                    sie_dp_tx = 1'($urandom_range(0, 1));
                    sie_dn_tx = 1'($urandom_range(0, 1));
                    set_line(2'($urandom_range(0, 3)));
                end
                hold(1);
            end
        end

        hold(2);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
